// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF-stage PC generator, IF/ID pipeline register, fault trap and counters
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        btb_hit,
  input  logic [31:0] pred_target,
  input  logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic        valid_d,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        pred_taken_d,
  output logic [31:0] pred_target_d,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] redirect_cnt,
  output logic [31:0] pred_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic        pred_taken_d_q, pred_taken_d_d;
  logic [31:0] pred_target_d_q, pred_target_d_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] pred_cnt_q, pred_cnt_d;

  logic        redirect_aligned;
  logic        redirect_misaligned;
  logic        fetch_valid;
  logic [31:0] btb_target;
  logic [31:0] pc_plus4;

  assign redirect_aligned    = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_valid         = (state_q == ST_RUN);
  assign btb_target          = {pred_target[31:2], 2'b00};
  assign pc_plus4            = pc_f_q + 32'd4;

  // FSM next state: a misaligned redirect traps, an aligned one releases the trap
  always_comb begin
    state_d    = state_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_misaligned) begin
          state_d    = ST_FAULT;
          fault_pc_d = redirect_pc;
        end
      end
      ST_FAULT: begin
        if (redirect_aligned) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Next fetch PC: aligned redirect beats stall, stall/fault hold, then BTB, then sequential
  always_comb begin
    pc_f_d = pc_f_q;
    if (redirect_aligned) begin
      pc_f_d = redirect_pc;
    end else if (stall_f || redirect_valid || (state_q == ST_FAULT)) begin
      pc_f_d = pc_f_q;
    end else if (btb_hit) begin
      pc_f_d = btb_target;
    end else begin
      pc_f_d = pc_plus4;
    end
  end

  // IF/ID next contents and performance counters
  always_comb begin
    valid_d_d       = valid_d_q;
    pc_d_d          = pc_d_q;
    instr_d_d       = instr_d_q;
    pred_taken_d_d  = pred_taken_d_q;
    pred_target_d_d = pred_target_d_q;
    pred_cnt_d      = pred_cnt_q;
    redirect_cnt_d  = redirect_valid ? redirect_cnt_q + 32'd1 : redirect_cnt_q;
    if (flush_d || redirect_valid) begin
      // Bubble only kills the valid/prediction bits; payload is don't-care
      valid_d_d      = 1'b0;
      pred_taken_d_d = 1'b0;
    end else if (!stall_d) begin
      valid_d_d       = fetch_valid;
      pc_d_d          = pc_f_q;
      instr_d_d       = instr_f;
      pred_taken_d_d  = btb_hit && fetch_valid;
      pred_target_d_d = btb_hit ? btb_target : pc_plus4;
      if (btb_hit && fetch_valid) begin
        pred_cnt_d = pred_cnt_q + 32'd1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_RUN;
      pc_f_q          <= RESET_PC;
      fault_pc_q      <= 32'd0;
      valid_d_q       <= 1'b0;
      pc_d_q          <= 32'd0;
      instr_d_q       <= 32'd0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'd0;
      redirect_cnt_q  <= 32'd0;
      pred_cnt_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_f_q          <= pc_f_d;
      fault_pc_q      <= fault_pc_d;
      valid_d_q       <= valid_d_d;
      pc_d_q          <= pc_d_d;
      instr_d_q       <= instr_d_d;
      pred_taken_d_q  <= pred_taken_d_d;
      pred_target_d_q <= pred_target_d_d;
      redirect_cnt_q  <= redirect_cnt_d;
      pred_cnt_q      <= pred_cnt_d;
    end
  end

  assign pc_f          = pc_f_q;
  assign valid_d       = valid_d_q;
  assign pc_d          = pc_d_q;
  assign instr_d       = instr_d_q;
  assign pred_taken_d  = pred_taken_d_q;
  assign pred_target_d = pred_target_d_q;
  assign fault         = (state_q == ST_FAULT);
  assign fault_pc      = fault_pc_q;
  assign redirect_cnt  = redirect_cnt_q;
  assign pred_cnt      = pred_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        btb_hit;
  logic [31:0] pred_target;
  logic [31:0] instr_f;

  logic [31:0] pc_f, pc_d, instr_d, pred_target_d, fault_pc, redirect_cnt, pred_cnt;
  logic        valid_d, pred_taken_d, fault;

  logic [31:0] w_pc_f, w_pc_d, w_instr_d, w_pred_target_d, w_fault_pc, w_redirect_cnt, w_pred_cnt;
  logic        w_valid_d, w_pred_taken_d, w_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word is a fixed tag xor the address
  assign instr_f = pc_f ^ 32'hA5A5_0000;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .btb_hit(btb_hit),
    .pred_target(pred_target), .instr_f(instr_f), .pc_f(pc_f), .valid_d(valid_d),
    .pc_d(pc_d), .instr_d(instr_d), .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
    .fault(fault), .fault_pc(fault_pc), .redirect_cnt(redirect_cnt), .pred_cnt(pred_cnt)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .btb_hit(btb_hit),
    .pred_target(pred_target), .instr_f(instr_f), .pc_f(w_pc_f), .valid_d(w_valid_d),
    .pc_d(w_pc_d), .instr_d(w_instr_d), .pred_taken_d(w_pred_taken_d), .pred_target_d(w_pred_target_d),
    .fault(w_fault), .fault_pc(w_fault_pc), .redirect_cnt(w_redirect_cnt), .pred_cnt(w_pred_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; btb_hit = 1'b0; pred_target = 32'd0;
    step();
    step();
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL reset_pc_f got=%h exp=%h", pc_f, 32'h0); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid_d got=%b exp=0", valid_d); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if ({pc_d, instr_d, pred_target_d, fault_pc} !== 128'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {pc_d, instr_d, pred_target_d, fault_pc}); end
    total++; if ({redirect_cnt, pred_cnt} !== 64'd0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {redirect_cnt, pred_cnt}); end
    total++; if (w_pc_f !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_wrap_pc got=%h exp=%h", w_pc_f, 32'hFFFF_FFF8); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    total++; if (pc_f !== 32'h4) begin bad++; $display("FAIL seq1_pc_f got=%h exp=%h", pc_f, 32'h4); end
    total++; if ({valid_d, pc_d, pred_taken_d} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL seq1_ifid got=%b/%h/%b exp=1/0/0", valid_d, pc_d, pred_taken_d); end
    total++; if ({instr_d, pred_target_d} !== {32'hA5A5_0000, 32'h4}) begin bad++; $display("FAIL seq1_payload got=%h/%h exp=a5a50000/4", instr_d, pred_target_d); end
    total++; if (w_pc_f !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap1_pc got=%h exp=fffffffc", w_pc_f); end
    step();
    total++; if (pc_f !== 32'h8) begin bad++; $display("FAIL seq2_pc_f got=%h exp=8", pc_f); end
    total++; if ({valid_d, pc_d, pred_taken_d} !== {1'b1, 32'h4, 1'b0}) begin bad++; $display("FAIL seq2_ifid got=%b/%h/%b exp=1/4/0", valid_d, pc_d, pred_taken_d); end
    total++; if (w_pc_f !== 32'h0) begin bad++; $display("FAIL wrap2_pc got=%h exp=0", w_pc_f); end
  endtask

  task automatic test_btb_hit();
    btb_hit = 1'b1; pred_target = 32'h0000_0102;
    step();
    btb_hit = 1'b0;
    total++; if (pc_f !== 32'h100) begin bad++; $display("FAIL btb_pc_f got=%h exp=100", pc_f); end
    total++; if ({valid_d, pc_d, pred_taken_d} !== {1'b1, 32'h8, 1'b1}) begin bad++; $display("FAIL btb_ifid got=%b/%h/%b exp=1/8/1", valid_d, pc_d, pred_taken_d); end
    total++; if (pred_target_d !== 32'h100) begin bad++; $display("FAIL btb_pred_target_d got=%h exp=100", pred_target_d); end
    total++; if (instr_d !== 32'hA5A5_0008) begin bad++; $display("FAIL btb_instr_d got=%h exp=a5a50008", instr_d); end
    total++; if (pred_cnt !== 32'd1) begin bad++; $display("FAIL btb_pred_cnt got=%0d exp=1", pred_cnt); end
  endtask

  task automatic test_stall_redirect();
    stall_f = 1'b1; stall_d = 1'b1;
    step();
    total++; if ({pc_f, valid_d, pc_d} !== {32'h100, 1'b1, 32'h8}) begin bad++; $display("FAIL stall1 got=%h/%b/%h exp=100/1/8", pc_f, valid_d, pc_d); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    total++; if (pc_f !== 32'h200) begin bad++; $display("FAIL stall_redir_pc got=%h exp=200", pc_f); end
    total++; if ({valid_d, pred_taken_d, pc_d} !== {1'b0, 1'b0, 32'h8}) begin bad++; $display("FAIL stall_redir_ifid got=%b/%b/%h exp=0/0/8", valid_d, pred_taken_d, pc_d); end
    total++; if (redirect_cnt !== 32'd1) begin bad++; $display("FAIL stall_redir_cnt got=%0d exp=1", redirect_cnt); end
    step();
    total++; if ({pc_f, valid_d} !== {32'h200, 1'b0}) begin bad++; $display("FAIL stall3 got=%h/%b exp=200/0", pc_f, valid_d); end
    stall_f = 1'b0; stall_d = 1'b0;
    step();
    total++; if ({pc_f, valid_d, pc_d, instr_d} !== {32'h204, 1'b1, 32'h200, 32'hA5A5_0200}) begin bad++; $display("FAIL unstall got=%h/%b/%h/%h exp=204/1/200/a5a50200", pc_f, valid_d, pc_d, instr_d); end
    total++; if (pred_cnt !== 32'd1) begin bad++; $display("FAIL unstall_pred_cnt got=%0d exp=1", pred_cnt); end
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    total++; if ({fault, fault_pc} !== {1'b1, 32'h203}) begin bad++; $display("FAIL fault_enter got=%b/%h exp=1/203", fault, fault_pc); end
    total++; if ({pc_f, valid_d} !== {32'h204, 1'b0}) begin bad++; $display("FAIL fault_hold got=%h/%b exp=204/0", pc_f, valid_d); end
    total++; if (redirect_cnt !== 32'd2) begin bad++; $display("FAIL fault_redirect_cnt got=%0d exp=2", redirect_cnt); end
    btb_hit = 1'b1; pred_target = 32'h400;
    step();
    btb_hit = 1'b0;
    total++; if ({fault, pc_f, valid_d, pred_taken_d} !== {1'b1, 32'h204, 1'b0, 1'b0}) begin bad++; $display("FAIL fault_btb got=%b/%h/%b/%b exp=1/204/0/0", fault, pc_f, valid_d, pred_taken_d); end
    total++; if (pred_cnt !== 32'd1) begin bad++; $display("FAIL fault_pred_cnt got=%0d exp=1", pred_cnt); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    total++; if ({fault, pc_f, valid_d} !== {1'b0, 32'h80, 1'b0}) begin bad++; $display("FAIL fault_exit got=%b/%h/%b exp=0/80/0", fault, pc_f, valid_d); end
    total++; if (redirect_cnt !== 32'd3) begin bad++; $display("FAIL exit_redirect_cnt got=%0d exp=3", redirect_cnt); end
    step();
    total++; if ({pc_f, valid_d, pc_d} !== {32'h84, 1'b1, 32'h80}) begin bad++; $display("FAIL after_fault got=%h/%b/%h exp=84/1/80", pc_f, valid_d, pc_d); end
  endtask

  task automatic test_flush();
    flush_d = 1'b1;
    step();
    flush_d = 1'b0;
    total++; if ({pc_f, valid_d, pc_d} !== {32'h88, 1'b0, 32'h80}) begin bad++; $display("FAIL flush got=%h/%b/%h exp=88/0/80", pc_f, valid_d, pc_d); end
  endtask

  task automatic test_reset_in_fault();
    redirect_valid = 1'b1; redirect_pc = 32'h81;
    step();
    redirect_valid = 1'b0;
    total++; if ({fault, redirect_cnt} !== {1'b1, 32'd4}) begin bad++; $display("FAIL refault got=%b/%0d exp=1/4", fault, redirect_cnt); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if ({pc_f, fault, valid_d} !== {32'h0, 1'b0, 1'b0}) begin bad++; $display("FAIL midreset got=%h/%b/%b exp=0/0/0", pc_f, fault, valid_d); end
    total++; if ({redirect_cnt, pred_cnt, fault_pc} !== 96'd0) begin bad++; $display("FAIL midreset_counters got=%h exp=0", {redirect_cnt, pred_cnt, fault_pc}); end
    step();
    total++; if ({pc_f, valid_d, pc_d} !== {32'h4, 1'b1, 32'h0}) begin bad++; $display("FAIL post_reset got=%h/%b/%h exp=4/1/0", pc_f, valid_d, pc_d); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_btb_hit();
    test_stall_redirect();
    test_fault();
    test_flush();
    test_reset_in_fault();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
